branch_redirect_ctrl: RTL and testbench

- Sequences PC update and pipeline flush/stall in response to EX-stage branch/jump resolution.
- Consumes the branch unit's taken flag (PcSel) and target (BrPC), plus the hazard unit's load-use stall and the instruction-fetch ready handshake.
- Owns the fetch PC register and holds a redirect pending while fetch is not ready.
- Drives IF/ID and ID/EX flush and stall controls, and keeps a taken-redirect performance counter.

---
 rtl/branch_redirect_ctrl_if.sv | 28 ++
 rtl/branch_redirect_ctrl.sv | 98 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_if.sv
// Handshake bundle between the branch/hazard/fetch units and the redirect controller.
// The master side drives the resolution inputs; the slave side returns PC and pipeline controls.
interface branch_redirect_ctrl_if #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
);
  logic              br_taken;
  logic [31:0]       br_target;
  logic              load_stall;
  logic              fetch_ready;
  logic [PC_W-1:0]   pc_out;
  logic              pc_stall;
  logic              flush_ifid;
  logic              flush_idex;
  logic              redirect_pending;
  logic              misalign;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output br_taken, br_target, load_stall, fetch_ready,
    input  pc_out, pc_stall, flush_ifid, flush_idex, redirect_pending, misalign, taken_cnt
  );

  modport slave (
    input  br_taken, br_target, load_stall, fetch_ready,
    output pc_out, pc_stall, flush_ifid, flush_idex, redirect_pending, misalign, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC owner: sequences EX-stage redirects into PC updates, IF/ID and ID/EX flushes and stalls,
// parking a redirect in PEND while instruction fetch is not ready.
module branch_redirect_ctrl #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input logic                   clk,
  input logic                   reset,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic {RUN, PEND} state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_sat;
  logic [PC_W-1:0]  tgt;
  logic             pc_stall, flush_ifid, flush_idex, misalign;
  logic             unused_target_hi;

  // Only the in-range, word-aligned part of the target reaches the PC.
  assign tgt              = {bus.br_target[PC_W-1:2], 2'b00};
  assign unused_target_hi = ^bus.br_target[31:PC_W];
  assign cnt_sat          = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    cnt_d      = cnt_q;
    pc_stall   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    misalign   = 1'b0;

    if (state_q == RUN) begin
      // A taken branch wins over load_stall: the stalled ID instruction is flushed anyway.
      if (bus.br_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        misalign   = |bus.br_target[1:0];
        cnt_d      = cnt_sat;
        if (bus.fetch_ready) begin
          pc_d = tgt;
        end else begin
          pend_pc_d = tgt;
          state_d   = PEND;
        end
      end else if (bus.load_stall || !bus.fetch_ready) begin
        pc_stall = 1'b1;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end else begin
      // EX holds a flushed bubble here, so new branch requests are ignored.
      flush_ifid = 1'b1;
      if (bus.fetch_ready) begin
        pc_d    = pend_pc_q;
        state_d = RUN;
      end
    end

    if (reset) begin
      pc_stall   = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      misalign   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.pc_out           = pc_q;
  assign bus.pc_stall         = pc_stall;
  assign bus.flush_ifid       = flush_ifid;
  assign bus.flush_idex       = flush_idex;
  assign bus.redirect_pending = (state_q == PEND);
  assign bus.misalign         = misalign;
  assign bus.taken_cnt        = cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: a cycle model checks every output each cycle,
// and literal expectations pin the key scenarios.
module tb_branch_redirect_ctrl;

  localparam int PC_W    = 9;
  localparam int CNT_W   = 2;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  branch_redirect_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_redirect_ctrl #(
    .PC_W    (PC_W),
    .RESET_PC('0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: fetch PC, a pending redirect (if any) and the redirect count.
  bit model_valid = 1'b0;
  int m_pc        = 0;
  bit m_pending   = 1'b0;
  int m_pend_tgt  = 0;
  int m_cnt       = 0;

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic bt, input logic [31:0] tgt,
                               input logic ls, input logic fr);
    @(posedge clk);
    #1;
    reset           = rst;
    bus.br_taken    = bt;
    bus.br_target   = tgt;
    bus.load_stall  = ls;
    bus.fetch_ready = fr;
    @(negedge clk);
  endtask

  // Model advances on each rising edge using the inputs presented that cycle.
  always @(posedge clk) begin
    int t;
    t = int'(bus.br_target % PC_MOD) / 4 * 4;
    if (reset) begin
      m_pc        = 0;
      m_pending   = 1'b0;
      m_pend_tgt  = 0;
      m_cnt       = 0;
      model_valid = 1'b1;
    end else if (m_pending) begin
      if (bus.fetch_ready) begin
        m_pc      = m_pend_tgt;
        m_pending = 1'b0;
      end
    end else if (bus.br_taken) begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (bus.fetch_ready) m_pc = t;
      else begin
        m_pending  = 1'b1;
        m_pend_tgt = t;
      end
    end else if (!bus.load_stall && bus.fetch_ready) begin
      m_pc = (m_pc + 4) % PC_MOD;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit e_stall, e_fi, e_fx, e_mis;
    if (model_valid) begin
      e_stall = 1'b0; e_fi = 1'b0; e_fx = 1'b0; e_mis = 1'b0;
      if (!reset) begin
        if (m_pending) e_fi = 1'b1;
        else if (bus.br_taken) begin
          e_fi  = 1'b1;
          e_fx  = 1'b1;
          e_mis = (bus.br_target % 4) != 0;
        end else if (bus.load_stall || !bus.fetch_ready) e_stall = 1'b1;
      end
      checkOutput("model pc_out", bus.pc_out, m_pc);
      checkOutput("model redirect_pending", bus.redirect_pending, m_pending);
      checkOutput("model taken_cnt", bus.taken_cnt, m_cnt);
      checkOutput("model pc_stall", bus.pc_stall, e_stall);
      checkOutput("model flush_ifid", bus.flush_ifid, e_fi);
      checkOutput("model flush_idex", bus.flush_idex, e_fx);
      checkOutput("model misalign", bus.misalign, e_mis);
    end
  end

  initial begin
    reset = 1'b1;
    bus.br_taken = 1'b0; bus.br_target = '0; bus.load_stall = 1'b0; bus.fetch_ready = 1'b0;

    applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("reset pc_out", bus.pc_out, 0);
    checkOutput("reset pc_stall", bus.pc_stall, 0);
    checkOutput("reset taken_cnt", bus.taken_cnt, 0);

    applyStimulus(0, 0, 32'h0, 0, 1);
    checkOutput("seq pc0", bus.pc_out, 9'h000);
    applyStimulus(0, 0, 32'h0, 0, 1);
    checkOutput("seq pc4", bus.pc_out, 9'h004);
    applyStimulus(0, 1, 32'h40, 0, 1);
    checkOutput("br pc8", bus.pc_out, 9'h008);
    checkOutput("br flush_ifid", bus.flush_ifid, 1);
    checkOutput("br flush_idex", bus.flush_idex, 1);
    applyStimulus(0, 0, 32'h0, 0, 1);
    checkOutput("br target pc", bus.pc_out, 9'h040);
    checkOutput("br cnt", bus.taken_cnt, 1);

    applyStimulus(0, 1, 32'h80, 0, 0);
    checkOutput("pend accept pc", bus.pc_out, 9'h044);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h1, 1, 0);
      checkOutput("pend flag", bus.redirect_pending, 1);
      checkOutput("pend pc hold", bus.pc_out, 9'h044);
      checkOutput("pend flush_idex", bus.flush_idex, 0);
      checkOutput("pend misalign", bus.misalign, 0);
    end
    applyStimulus(0, 0, 32'h0, 0, 1);
    checkOutput("pend release flag", bus.redirect_pending, 1);

    applyStimulus(0, 1, 32'h20, 1, 1);
    checkOutput("pend target pc", bus.pc_out, 9'h080);
    checkOutput("pend cnt once", bus.taken_cnt, 2);
    checkOutput("br over load pc_stall", bus.pc_stall, 0);
    checkOutput("br over load flush_idex", bus.flush_idex, 1);
    applyStimulus(0, 0, 32'h0, 1, 1);
    checkOutput("br over load pc", bus.pc_out, 9'h020);
    checkOutput("load stall", bus.pc_stall, 1);
    checkOutput("load no flush", bus.flush_idex, 0);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkOutput("not ready hold pc", bus.pc_out, 9'h020);
    checkOutput("not ready stall", bus.pc_stall, 1);

    applyStimulus(0, 1, 32'h1FE, 0, 1);
    checkOutput("misalign pulse", bus.misalign, 1);
    applyStimulus(0, 0, 32'h0, 0, 1);
    checkOutput("misalign target pc", bus.pc_out, 9'h1FC);
    checkOutput("misalign one cycle", bus.misalign, 0);
    applyStimulus(0, 1, 32'hABCD_E104, 0, 1);
    checkOutput("pc wrap", bus.pc_out, 9'h000);
    applyStimulus(0, 0, 32'h0, 0, 1);
    checkOutput("high bits dropped", bus.pc_out, 9'h104);
    checkOutput("cnt saturated", bus.taken_cnt, 3);

    applyStimulus(0, 1, 32'h10, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkOutput("pend before reset", bus.redirect_pending, 1);
    applyStimulus(1, 1, 32'h30, 1, 0);
    checkOutput("reset forces flush_ifid", bus.flush_ifid, 0);
    applyStimulus(0, 0, 32'h0, 0, 1);
    checkOutput("reset mid-pend pc", bus.pc_out, 9'h000);
    checkOutput("reset mid-pend flag", bus.redirect_pending, 0);
    checkOutput("reset mid-pend cnt", bus.taken_cnt, 0);
    applyStimulus(0, 0, 32'h0, 0, 1);
    checkOutput("after reset seq", bus.pc_out, 9'h004);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
